// File: rtl/audio_fifo_bridge.sv
// Bus-mapped stream FIFO: a producer pushes words, the host pops them through DATA
// and manages a watermark/overflow interrupt through STATUS, CTRL and CMD.
module audio_fifo_bridge #(
    parameter int DATA_SIZE = 28,
    parameter int DEPTH     = 64,
    parameter int LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chipselect,
    input  logic [1:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    input  logic                 source_valid,
    input  logic [DATA_SIZE-1:0] source_data,
    output logic                 source_ready,
    output logic                 irq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_CMD    = 2'd3;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] wm_q, wm_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             irq_pend_q, irq_pend_d;
    logic             wm_ie_q, wm_ie_d;
    logic             ovf_ie_q, ovf_ie_d;
    logic [31:0]      read_data_q, read_data_d;

    logic        full, empty;
    logic        rd_qual, wr_qual;
    logic        push, pop, flush, cmd_wr, ctrl_wr;
    logic [31:0] head_word, status_word, ctrl_word;
    logic [15:0] wm_wr;
    logic        unused_wdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + PTR_W'(1);
    endfunction

    assign full         = (level_q == DEPTH_L);
    assign empty        = (level_q == '0);
    assign source_ready = !full;
    assign read_data    = read_data_q;
    assign irq          = irq_pend_q;
    assign unused_wdata = ^write_data[31:18];

    // A read strobe wins over a write strobe in the same bus cycle.
    assign rd_qual = chipselect && read;
    assign wr_qual = chipselect && write && !read;
    assign cmd_wr  = wr_qual && (address == ADDR_CMD);
    assign ctrl_wr = wr_qual && (address == ADDR_CTRL);
    assign flush   = cmd_wr && write_data[0];
    assign pop     = rd_qual && (address == ADDR_DATA) && !empty;
    assign push    = source_valid && !full && !flush;
    assign wm_wr   = write_data[15:0];

    always_comb begin
        head_word                   = '0;
        head_word[DATA_SIZE-1:0]    = mem_q[rd_ptr_q];

        status_word                 = '0;
        status_word[31]             = ovf_q;
        status_word[30]             = unf_q;
        status_word[29]             = irq_pend_q;
        status_word[17]             = full;
        status_word[16]             = empty;
        status_word[LVL_W-1:0]      = level_q;

        ctrl_word                   = '0;
        ctrl_word[LVL_W-1:0]        = wm_q;
        ctrl_word[16]               = wm_ie_q;
        ctrl_word[17]               = ovf_ie_q;

        read_data_d = '0;
        if (rd_qual) begin
            case (address)
                ADDR_DATA:   read_data_d = empty ? '0 : head_word;
                ADDR_STATUS: read_data_d = status_word;
                ADDR_CTRL:   read_data_d = ctrl_word;
                default:     read_data_d = '0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      level_d = level_q + LVL_W'(1);
            else if (pop && !push) level_d = level_q - LVL_W'(1);
        end
    end

    always_comb begin
        // Same-cycle set beats a CMD clear so an event is never lost.
        ovf_d = (ovf_q && !(cmd_wr && write_data[1])) || (source_valid && full);
        unf_d = (unf_q && !(cmd_wr && write_data[2])) ||
                (rd_qual && (address == ADDR_DATA) && empty);

        wm_d     = wm_q;
        wm_ie_d  = wm_ie_q;
        ovf_ie_d = ovf_ie_q;
        if (ctrl_wr) begin
            wm_d     = (wm_wr > 16'(DEPTH)) ? DEPTH_L : wm_wr[LVL_W-1:0];
            wm_ie_d  = write_data[16];
            ovf_ie_d = write_data[17];
        end

        irq_pend_d = (wm_ie_q && (wm_q != '0) && (level_q >= wm_q)) || (ovf_ie_q && ovf_q);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= source_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wm_q        <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            irq_pend_q  <= 1'b0;
            wm_ie_q     <= 1'b0;
            ovf_ie_q    <= 1'b0;
            read_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            wm_q        <= wm_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            irq_pend_q  <= irq_pend_d;
            wm_ie_q     <= wm_ie_d;
            ovf_ie_q    <= ovf_ie_d;
            read_data_q <= read_data_d;
        end
    end

endmodule

// File: tb/tb_audio_fifo_bridge.sv
// Bench for audio_fifo_bridge: DEPTH=4 and DEPTH=5 instances share stimulus and are
// compared against a queue-based reference model plus directed constants.
module tb_audio_fifo_bridge;

    localparam int DW = 28;

    logic          clk = 1'b0;
    logic          reset, cs, rd, wr, sv;
    logic [1:0]    addr;
    logic [31:0]   wd;
    logic [DW-1:0] sd;
    logic [31:0]   rdat0, rdat1;
    logic          srdy0, srdy1, irq0, irq1;

    always #5 clk = ~clk;

    audio_fifo_bridge #(.DATA_SIZE(DW), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .chipselect(cs), .address(addr), .read(rd),
        .write(wr), .write_data(wd), .read_data(rdat0), .source_valid(sv),
        .source_data(sd), .source_ready(srdy0), .irq(irq0)
    );

    audio_fifo_bridge #(.DATA_SIZE(DW), .DEPTH(5)) u_d5 (
        .clk(clk), .reset(reset), .chipselect(cs), .address(addr), .read(rd),
        .write(wr), .write_data(wd), .read_data(rdat1), .source_valid(sv),
        .source_data(sd), .source_ready(srdy1), .irq(irq1)
    );

    // Reference model state per instance (0: DEPTH=4, 1: DEPTH=5)
    logic [DW-1:0] q0[$], q1[$];
    int unsigned   m_depth [2] = '{4, 5};
    logic [31:0]   m_rd [2];
    bit            m_ovf [2], m_unf [2], m_pend [2], m_wmie [2], m_ovfie [2];
    int unsigned   m_wm [2];
    int            n_pass = 0;
    int            n_total = 0;

    function automatic logic [31:0] get_rd(input int k);
        return (k == 0) ? rdat0 : rdat1;
    endfunction
    function automatic logic get_srdy(input int k);
        return (k == 0) ? srdy0 : srdy1;
    endfunction
    function automatic logic get_irq(input int k);
        return (k == 0) ? irq0 : irq1;
    endfunction
    function automatic bit exp_srdy(input int k);
        return ((k == 0) ? q0.size() : q1.size()) < m_depth[k];
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [DW-1:0] q[$];
            int unsigned   d, lvl;
            bit            full, empty, qrd, qwr, pend_n;
            logic [31:0]   r;
            if (k == 0) q = q0; else q = q1;
            d     = m_depth[k];
            lvl   = q.size();
            full  = (lvl == d);
            empty = (lvl == 0);
            if (reset) begin
                q.delete();
                m_rd[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_pend[k] = 0;
                m_wm[k] = 0; m_wmie[k] = 0; m_ovfie[k] = 0;
            end else begin
                qrd    = cs && rd;
                qwr    = cs && wr && !rd;
                pend_n = (m_wmie[k] && m_wm[k] != 0 && lvl >= m_wm[k]) || (m_ovfie[k] && m_ovf[k]);
                r      = 0;
                if (qrd) begin
                    case (addr)
                        2'd0: if (empty) m_unf[k] = 1;
                              else begin r = 32'(q[0]); void'(q.pop_front()); end
                        2'd1: r = {m_ovf[k], m_unf[k], m_pend[k], 11'b0, full, empty, 16'(lvl)};
                        2'd2: r = {14'b0, m_ovfie[k], m_wmie[k], 16'(m_wm[k])};
                        default: r = 0;
                    endcase
                end
                if (qwr && addr == 2'd2) begin
                    m_wm[k]    = (wd[15:0] > d) ? d : int'(wd[15:0]);
                    m_wmie[k]  = wd[16];
                    m_ovfie[k] = wd[17];
                end
                if (qwr && addr == 2'd3) begin
                    if (wd[1]) m_ovf[k] = 0;
                    if (wd[2]) m_unf[k] = 0;
                end
                if (sv && full) m_ovf[k] = 1;
                if (qwr && addr == 2'd3 && wd[0]) q.delete();
                else if (sv && !full) q.push_back(sd);
                m_rd[k]   = r;
                m_pend[k] = pend_n;
            end
            if (k == 0) q0 = q; else q1 = q;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        reset = 0; cs = 0; rd = 0; wr = 0; sv = 0; addr = 0; wd = 0; sd = 0;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        cs = 1; rd = 1; addr = a;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        cs = 1; wr = 1; addr = a; wd = d;
    endtask

    task automatic test_reset();
        reset = 1; cycle();
        reset = 1; cycle();
        n_total++; if (rdat0 !== 32'h0) $display("FAIL reset.rd: got %h want 0", rdat0); else n_pass++;
        n_total++; if (srdy0 !== 1'b1) $display("FAIL reset.srdy: got %b want 1", srdy0); else n_pass++;
        n_total++; if (irq1 !== 1'b0) $display("FAIL reset.irq: got %b want 0", irq1); else n_pass++;
        bus_rd(1); cycle();
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (get_rd(k) !== 32'h0001_0000) $display("FAIL reset.status[%0d]: got %h want 00010000", k, get_rd(k));
            else n_pass++;
        end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] vals [3];
        vals = '{28'hA, 28'hB, 28'hC};
        for (int i = 0; i < 3; i++) begin sv = 1; sd = vals[i]; cycle(); end
        bus_rd(1); cycle();
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (get_rd(k) !== 32'h0000_0003) $display("FAIL fill.status[%0d]: got %h want 00000003", k, get_rd(k));
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            bus_rd(0); cycle();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (get_rd(k) !== 32'(vals[i]) || get_rd(k) !== m_rd[k])
                    $display("FAIL drain.data[%0d] #%0d: got %h want %h", k, i, get_rd(k), 32'(vals[i]));
                else n_pass++;
            end
        end
        bus_rd(1); cycle();
        n_total++; if (rdat0 !== 32'h0001_0000) $display("FAIL drain.status: got %h want 00010000", rdat0); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            sv = 1; sd = DW'($urandom); cycle();
            n_total++;
            if (srdy0 !== (i < 4)) $display("FAIL ovf.srdy4 after %0d: got %b want %b", i, srdy0, (i < 4));
            else n_pass++;
            n_total++;
            if (srdy1 !== exp_srdy(1)) $display("FAIL ovf.srdy5 after %0d: got %b want %b", i, srdy1, exp_srdy(1));
            else n_pass++;
        end
        bus_rd(1); cycle();
        n_total++; if (rdat0 !== 32'h8002_0004) $display("FAIL ovf.status4: got %h want 80020004", rdat0); else n_pass++;
        n_total++; if (rdat1 !== 32'h0002_0005) $display("FAIL ovf.status5: got %h want 00020005", rdat1); else n_pass++;
        bus_wr(3, 32'h3); cycle();
        bus_rd(1); cycle();
        n_total++; if (rdat0 !== 32'h0001_0000) $display("FAIL ovf.cleared: got %h want 00010000", rdat0); else n_pass++;
    endtask

    task automatic test_underflow();
        bus_rd(0); cycle();
        n_total++; if (rdat0 !== 32'h0) $display("FAIL unf.data: got %h want 0", rdat0); else n_pass++;
        bus_rd(1); cycle();
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (get_rd(k) !== 32'h4001_0000) $display("FAIL unf.status[%0d]: got %h want 40010000", k, get_rd(k));
            else n_pass++;
        end
        bus_wr(3, 32'h4); cycle();
        bus_rd(1); cycle();
        n_total++; if (rdat1 !== 32'h0001_0000) $display("FAIL unf.clear: got %h want 00010000", rdat1); else n_pass++;
    endtask

    task automatic test_wrap();
        sv = 1; sd = DW'($urandom); cycle();
        for (int i = 0; i < 12; i++) begin
            sv = 1; sd = DW'($urandom); bus_rd(0); cycle();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (get_rd(k) !== m_rd[k]) $display("FAIL wrap.data[%0d] #%0d: got %h want %h", k, i, get_rd(k), m_rd[k]);
                else n_pass++;
            end
        end
        bus_rd(1); cycle();
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (get_rd(k) !== 32'h0000_0001) $display("FAIL wrap.level[%0d]: got %h want 00000001", k, get_rd(k));
            else n_pass++;
        end
        bus_wr(3, 32'h1); cycle();
    endtask

    task automatic test_watermark();
        bus_wr(2, 32'h0001_0003); cycle();
        bus_rd(2); cycle();
        n_total++; if (rdat0 !== 32'h0001_0003) $display("FAIL wm.ctrl: got %h want 00010003", rdat0); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            sv = 1; sd = DW'($urandom); cycle();
            n_total++; if (irq0 !== 1'b0) $display("FAIL wm.irq_low push %0d: got %b want 0", i, irq0); else n_pass++;
        end
        cycle();
        n_total++; if (irq0 !== 1'b1) $display("FAIL wm.irq_rise: got %b want 1", irq0); else n_pass++;
        n_total++; if (irq1 !== m_pend[1]) $display("FAIL wm.irq5: got %b want %b", irq1, m_pend[1]); else n_pass++;
        bus_rd(0); cycle();
        n_total++; if (irq0 !== 1'b1) $display("FAIL wm.irq_hold: got %b want 1", irq0); else n_pass++;
        cycle();
        n_total++; if (irq0 !== 1'b0) $display("FAIL wm.irq_fall: got %b want 0", irq0); else n_pass++;
    endtask

    task automatic test_flush_push();
        sv = 1; sd = DW'($urandom); cycle();
        bus_wr(3, 32'h1); sv = 1; sd = DW'($urandom); cycle();
        bus_rd(1); cycle();
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (get_rd(k) !== m_rd[k]) $display("FAIL flush.status[%0d]: got %h want %h", k, get_rd(k), m_rd[k]);
            else n_pass++;
        end
        n_total++; if (irq0 !== 1'b0) $display("FAIL flush.irq: got %b want 0", irq0); else n_pass++;
        bus_rd(1); cycle();
        n_total++; if (rdat0 !== 32'h0001_0000) $display("FAIL flush.empty: got %h want 00010000", rdat0); else n_pass++;
    endtask

    task automatic test_clamp();
        bus_wr(2, 32'h0002_0064); cycle();
        bus_rd(2); cycle();
        n_total++; if (rdat0 !== 32'h0002_0004) $display("FAIL clamp.d4: got %h want 00020004", rdat0); else n_pass++;
        n_total++; if (rdat1 !== 32'h0002_0005) $display("FAIL clamp.d5: got %h want 00020005", rdat1); else n_pass++;
        bus_rd(3); wr = 1; wd = 32'h1; cycle();
        n_total++; if (rdat0 !== 32'h0) $display("FAIL cmd.read: got %h want 0", rdat0); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            sv    = $urandom_range(0, 1);
            sd    = DW'($urandom);
            cs    = ($urandom_range(0, 9) < 7);
            rd    = $urandom_range(0, 1);
            wr    = $urandom_range(0, 1);
            addr  = 2'($urandom_range(0, 3));
            wd    = $urandom;
            if (addr == 2'd2) wd[15:0] = 16'($urandom_range(0, 7));
            if (addr == 2'd3) wd[0] = ($urandom_range(0, 7) == 0);
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (get_rd(k) !== m_rd[k] || get_srdy(k) !== exp_srdy(k) || get_irq(k) !== m_pend[k])
                    $display("FAIL random[%0d] cyc %0d: got rd=%h rdy=%b irq=%b want rd=%h rdy=%b irq=%b",
                             k, i, get_rd(k), get_srdy(k), get_irq(k), m_rd[k], exp_srdy(k), m_pend[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bus_wr(2, 32'h0003_0001); cycle();
        for (int i = 0; i < 2; i++) begin sv = 1; sd = DW'($urandom); cycle(); end
        reset = 1; sv = 1; sd = DW'($urandom); bus_wr(2, 32'h0003_0002); cycle();
        n_total++; if (rdat0 !== 32'h0) $display("FAIL rstmid.rd: got %h want 0", rdat0); else n_pass++;
        n_total++; if (srdy0 !== 1'b1 || srdy1 !== 1'b1) $display("FAIL rstmid.srdy: got %b%b want 11", srdy0, srdy1); else n_pass++;
        n_total++; if (irq0 !== 1'b0 || irq1 !== 1'b0) $display("FAIL rstmid.irq: got %b%b want 00", irq0, irq1); else n_pass++;
        bus_rd(1); cycle();
        n_total++; if (rdat0 !== 32'h0001_0000) $display("FAIL rstmid.status: got %h want 00010000", rdat0); else n_pass++;
        bus_rd(2); cycle();
        n_total++; if (rdat1 !== 32'h0) $display("FAIL rstmid.ctrl: got %h want 0", rdat1); else n_pass++;
    endtask

    initial begin
        reset = 1; cs = 0; rd = 0; wr = 0; sv = 0; addr = 0; wd = 0; sd = 0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_watermark();
        test_flush_push();
        test_clamp();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
